// File: rtl/icache_dual.sv
// Direct-mapped dual-fetch instruction cache. Returns the words at pc and
// pc+4 in the same cycle. A three-state FSM refills one 16-byte line at a
// time from main memory.

// Per-lane lookup: splits a fetch address and compares it against the stored tag.
module icache_dual_lookup #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic [31:0]      addr,
  input  logic [TAG_W-1:0] storedTag,
  input  logic             storedValid,
  output logic [IDX_W-1:0] idx,
  output logic [TAG_W-1:0] tag,
  output logic [1:0]       word,
  output logic             laneHit
);
  // The byte offset within a word has no meaning for instruction fetch.
  logic unusedLow;
  assign unusedLow = ^addr[1:0];

  assign tag     = addr[31:4+IDX_W];
  assign idx     = addr[4+IDX_W-1:4];
  assign word    = addr[3:2];
  assign laneHit = storedValid & (storedTag == tag);
endmodule

module icache_dual #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        invalidate,
  output logic [31:0] instr1,
  output logic [31:0] instr2,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int TAG_W     = 28 - IDX_W;
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t state, stateNext;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tagArr  [NUM_LINES];
  logic [31:0]          dataArr [NUM_LINES][WORDS_PER_LINE];

  // Lane 0 is the line holding pc, lane 1 the line holding pc+4 (wraps mod 2^32).
  logic [NUM_LANES-1:0][31:0]      laneAddr;
  logic [NUM_LANES-1:0][TAG_W-1:0] laneStoredTag;
  logic [NUM_LANES-1:0]            laneValid;
  logic [NUM_LANES-1:0][IDX_W-1:0] laneIdx;
  logic [NUM_LANES-1:0][TAG_W-1:0] laneTag;
  logic [NUM_LANES-1:0][1:0]       laneWord;
  logic [NUM_LANES-1:0]            laneHit;
  logic [NUM_LANES-1:0][31:0]      laneData;

  logic [1:0]       cnt;
  logic [IDX_W-1:0] fillIdx;
  logic [TAG_W-1:0] fillTag;
  logic             kill;

  logic             missA, missB, lastWord;
  logic [IDX_W-1:0] tIdx;
  logic [TAG_W-1:0] tTag;

  assign laneAddr[0] = pc;
  assign laneAddr[1] = pc + 32'd4;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    assign laneStoredTag[g] = tagArr[laneIdx[g]];
    assign laneValid[g]     = valid[laneIdx[g]];
    assign laneData[g]      = dataArr[laneIdx[g]][laneWord[g]];

    icache_dual_lookup #(.IDX_W(IDX_W), .TAG_W(TAG_W)) uLane (
      .addr       (laneAddr[g]),
      .storedTag  (laneStoredTag[g]),
      .storedValid(laneValid[g]),
      .idx        (laneIdx[g]),
      .tag        (laneTag[g]),
      .word       (laneWord[g]),
      .laneHit    (laneHit[g])
    );
  end

  assign hit    = laneHit[0] & laneHit[1] & (state == IDLE);
  assign instr1 = hit ? laneData[0] : 32'd0;
  assign instr2 = hit ? laneData[1] : 32'd0;

  // Line A is always serviced before line B when both miss.
  assign missA    = ~laneHit[0];
  assign missB    = ~laneHit[1];
  assign tIdx     = missA ? laneIdx[0] : laneIdx[1];
  assign tTag     = missA ? laneTag[0] : laneTag[1];
  assign lastWord = (state == FILL) && mem_rvalid && (cnt == 2'(WORDS_PER_LINE - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state: invalidate in IDLE suppresses miss handling for that cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (!invalidate && (missA || missB)) stateNext = REQ;
      REQ:     if (mem_ack) stateNext = FILL;
      FILL:    if (lastWord) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Refill control: request/address, word counter, valid bits and kill flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cnt      <= '0;
      fillIdx  <= '0;
      fillTag  <= '0;
      kill     <= 1'b0;
      valid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (invalidate) begin
            valid <= '0;
          end else if (missA || missB) begin
            fillIdx       <= tIdx;
            fillTag       <= tTag;
            valid[tIdx]   <= 1'b0;
            mem_addr      <= {tTag, tIdx, 4'b0000};
            mem_req       <= 1'b1;
          end
        end
        REQ: begin
          if (invalidate) begin
            kill  <= 1'b1;
            valid <= '0;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            cnt     <= '0;
          end
        end
        FILL: begin
          if (invalidate) begin
            kill  <= 1'b1;
            valid <= '0;
          end
          if (mem_rvalid) cnt <= cnt + 2'd1;
          // A line refilled across an invalidate is stale: complete it but leave it invalid.
          if (lastWord) begin
            valid[fillIdx] <= ~(kill | invalidate);
            kill           <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (state == FILL && mem_rvalid) begin
      dataArr[fillIdx][cnt] <= mem_rdata;
      if (lastWord) tagArr[fillIdx] <= fillTag;
    end
  end
endmodule

// File: tb/tb_icache_dual.sv
// Scoreboard bench for icache_dual: stimulus queues expected line requests and
// instruction pairs; a negedge monitor checks them as the DUT presents them.
module tb_icache_dual;
  logic        clk = 1'b0;
  logic        rst, invalidate, mem_ack, mem_rvalid;
  logic [31:0] pc, mem_rdata;
  logic [31:0] instr1, instr2, mem_addr;
  logic        hit, mem_req;

  icache_dual dut (
    .clk(clk), .rst(rst), .pc(pc), .invalidate(invalidate),
    .instr1(instr1), .instr2(instr2), .hit(hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
  } hitExp_t;

  hitExp_t     hitQ[$];
  logic [31:0] reqQ[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expHit(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    hitExp_t e;
    e.pc = p; e.i1 = a; e.i2 = b;
    hitQ.push_back(e);
  endtask

  // Monitor: a rising mem_req pops an expected line address; a new hit
  // (rising, or pc moved while hitting) pops an expected instruction pair.
  logic        prevReq = 1'b0, prevHit = 1'b0;
  logic [31:0] prevPc = 32'd0;
  hitExp_t     monHit;
  logic [31:0] monAddr;
  always @(negedge clk) begin
    if (mem_req && !prevReq) begin
      if (reqQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
      end else begin
        monAddr = reqQ.pop_front();
        check32("mem_addr", mem_addr, monAddr);
      end
    end
    if (hit && (!prevHit || pc != prevPc)) begin
      if (hitQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_hit: got hit at pc %h expected none", pc);
      end else begin
        monHit = hitQ.pop_front();
        check32("instr1", instr1, monHit.i1);
        check32("instr2", instr2, monHit.i2);
      end
    end
    prevReq <= mem_req;
    prevHit <= hit;
    prevPc  <= pc;
  end

  task automatic setPc(input logic [31:0] v);
    @(posedge clk); #1;
    pc = v;
  endtask

  // Wait for a line request, hold ack off for ackDelay cycles, then accept it.
  task automatic waitReq(input logic [31:0] expAddr, input int ackDelay);
    int n = 0;
    @(negedge clk);
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no mem_req expected addr %h", expAddr);
      return;
    end
    for (int d = 0; d < ackDelay; d++) begin
      @(negedge clk);
      check32("addr_hold", mem_addr, expAddr);
      checkBit("req_hold", mem_req, 1'b1);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkBit("req_drop", mem_req, 1'b0);
  endtask

  // Deliver nWords refill words following an rvalid pattern (LSB first, then all ones).
  task automatic feed(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                      input logic [31:0] w3, input logic [7:0] pat, input int nWords);
    logic [31:0] w[4];
    int   k = 0;
    int   p = 0;
    logic b;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    while (k < nWords && p < 16) begin
      b = (p < 8) ? pat[p] : 1'b1;
      mem_rvalid = b;
      mem_rdata  = b ? w[k] : 32'hDEADBEEF;
      @(negedge clk);
      checkBit("no_hit_in_fill", hit, 1'b0);
      @(posedge clk); #1;
      if (b) k++;
      p++;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  task automatic waitHit(input int t0, input int expLat);
    int n = 0;
    @(negedge clk);
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL hit_timeout: got hit=0 expected hit at pc %h", pc);
    end else if (expLat >= 0) begin
      check32("hit_latency", 32'(cyc - t0), 32'(expLat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b0; pc = 32'd0; invalidate = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    checkBit("rst_hit", hit, 1'b0);
    checkBit("rst_req", mem_req, 1'b0);
    check32("rst_addr", mem_addr, 32'd0);
    check32("rst_instr1", instr1, 32'd0);
    check32("rst_instr2", instr2, 32'd0);

    // Cold miss on line 0.
    reqQ.push_back(32'h0);
    expHit(32'h0, 32'h11, 32'h22);
    @(posedge clk); #1;
    rst = 1'b1;
    t0 = cyc;
    waitReq(32'h0, 0);
    feed(32'h11, 32'h22, 32'h33, 32'h44, 8'hFF, 4);
    waitHit(t0, 6);

    // Same-line hit, no memory traffic.
    expHit(32'h8, 32'h33, 32'h44);
    setPc(32'h8);
    @(negedge clk);
    checkBit("same_line_hit", hit, 1'b1);
    checkBit("same_line_req", mem_req, 1'b0);
    repeat (3) @(negedge clk);
    checkBit("same_line_req_later", mem_req, 1'b0);

    // Line crossing: only line B misses.
    reqQ.push_back(32'h10);
    expHit(32'hC, 32'h44, 32'h55);
    setPc(32'hC);
    waitReq(32'h10, 0);
    feed(32'h55, 32'h66, 32'h77, 32'h88, 8'hFF, 4);
    waitHit(0, -1);

    // Conflict: 0x400 shares index 0 with 0x0.
    reqQ.push_back(32'h400);
    expHit(32'h400, 32'hA1, 32'hA2);
    setPc(32'h400);
    waitReq(32'h400, 0);
    feed(32'hA1, 32'hA2, 32'hA3, 32'hA4, 8'hFF, 4);
    waitHit(0, -1);

    // 0x0 was evicted; refill it with a late ack and gapped rvalid 1-0-1-0-1-1.
    reqQ.push_back(32'h0);
    expHit(32'h0, 32'h99, 32'hAA);
    setPc(32'h0);
    @(negedge clk);
    checkBit("evicted_miss", hit, 1'b0);
    waitReq(32'h0, 3);
    feed(32'h99, 32'hAA, 32'hBB, 32'hCC, 8'b0011_0101, 4);
    waitHit(0, -1);
    expHit(32'h8, 32'hBB, 32'hCC);
    setPc(32'h8);
    @(negedge clk);
    checkBit("gapped_words_order", hit, 1'b1);

    // Reset after two words, then refill the same pc from scratch.
    reqQ.push_back(32'h20);
    setPc(32'h20);
    waitReq(32'h20, 0);
    feed(32'hC1, 32'hC2, 32'hC3, 32'hC4, 8'hFF, 2);
    rst = 1'b0;
    #1;
    checkBit("midfill_rst_req", mem_req, 1'b0);
    @(negedge clk);
    checkBit("midfill_rst_hit", hit, 1'b0);
    check32("midfill_rst_addr", mem_addr, 32'd0);
    reqQ.push_back(32'h20);
    expHit(32'h20, 32'hD1, 32'hD2);
    @(posedge clk); #1;
    rst = 1'b1;
    waitReq(32'h20, 0);
    feed(32'hD1, 32'hD2, 32'hD3, 32'hD4, 8'hFF, 4);
    waitHit(0, -1);

    // Invalidate after two words: fill completes unmarked, line is re-requested.
    reqQ.push_back(32'h30);
    reqQ.push_back(32'h30);
    expHit(32'h30, 32'h3200_0001, 32'h3200_0002);
    setPc(32'h30);
    waitReq(32'h30, 0);
    feed(32'h3100_0001, 32'h3100_0002, 32'h0, 32'h0, 8'hFF, 2);
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    feed(32'h3100_0003, 32'h3100_0004, 32'h0, 32'h0, 8'hFF, 2);
    @(negedge clk);
    checkBit("killed_line_hit", hit, 1'b0);
    waitReq(32'h30, 0);
    feed(32'h3200_0001, 32'h3200_0002, 32'h3200_0003, 32'h3200_0004, 8'hFF, 4);
    waitHit(0, -1);

    // The invalidate also dropped line 0x20.
    reqQ.push_back(32'h20);
    expHit(32'h20, 32'hF1, 32'hF2);
    setPc(32'h20);
    @(negedge clk);
    checkBit("inv_cleared_other", hit, 1'b0);
    waitReq(32'h20, 0);
    feed(32'hF1, 32'hF2, 32'hF3, 32'hF4, 8'hFF, 4);
    waitHit(0, -1);

    // Address wrap: double miss, line A then line 0, back to back.
    reqQ.push_back(32'hFFFF_FFF0);
    reqQ.push_back(32'h0);
    expHit(32'hFFFF_FFFC, 32'hA000_0004, 32'hB000_0001);
    setPc(32'hFFFF_FFFC);
    t0 = cyc;
    waitReq(32'hFFFF_FFF0, 0);
    feed(32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 8'hFF, 4);
    waitReq(32'h0, 0);
    feed(32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004, 8'hFF, 4);
    waitHit(t0, 12);

    // Invalidate in IDLE: no request on that edge, hit drops, both lines refetched.
    reqQ.push_back(32'hFFFF_FFF0);
    reqQ.push_back(32'h0);
    expHit(32'hFFFF_FFFC, 32'hA000_0004, 32'hB000_0001);
    @(posedge clk); #1;
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    checkBit("inv_idle_no_req", mem_req, 1'b0);
    @(negedge clk);
    checkBit("inv_idle_hit", hit, 1'b0);
    waitReq(32'hFFFF_FFF0, 0);
    feed(32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004, 8'hFF, 4);
    waitReq(32'h0, 0);
    feed(32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004, 8'hFF, 4);
    waitHit(0, -1);

    repeat (3) @(negedge clk);
    check32("reqQ_drained", 32'(reqQ.size()), 32'd0);
    check32("hitQ_drained", 32'(hitQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache_dual.md
Name: icache_dual

Overview:
- Direct-mapped instruction cache that feeds the fetch stage of the dual-issue pipeline.
- Each cycle it returns the instruction pair at pc and pc+4, plus a single hit flag. Fetch stalls while hit is low.
- On a miss, a refill FSM fetches whole lines from main memory over a request/acknowledge + per-word valid interface.

Parameters:
- NUM_LINES, 64, number of cache lines; power of 2, minimum 2.
- WORDS_PER_LINE, 4, words per line; fixed at 4 (line = 16 bytes).
- Derived: IDX_W = log2(NUM_LINES); TAG_W = 28 - IDX_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  32  fetch address; pc[1:0] ignored.
- invalidate  in  1  single-cycle pulse that clears all valid bits.
- instr1  out  32  instruction at pc.
- instr2  out  32  instruction at pc+4.
- hit  out  1  both instructions valid this cycle.
- mem_req  out  1  line-read request to main memory.
- mem_addr  out  32  line-aligned address; bits [3:0] always 0.
- mem_ack  in  1  memory accepted the request.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- mem_rdata  in  32  refill word; words arrive in ascending order.

Behaviour:
- Address split: tag = pc[31:4+IDX_W], idx = pc[4+IDX_W-1:4], word = pc[3:2].
- Line A is the line holding pc. Line B is the line holding pc+4, which is line A except when word==3.
- Lookup is combinational, with zero-cycle latency:
  - hitA = valid[idxA] & (tagArr[idxA] == tagA).
  - hitB is computed the same way for line B.
  - hit = hitA & hitB & (state == IDLE).
- instr1 and instr2 are read combinationally from the data array. Both are forced to 0 when hit=0.
- Address wrap: pc = 0xFFFFFFFC gives pc+4 = 0x00000000, using normal modulo-2^32 arithmetic.
- Reset (async, any time, including mid-refill):
  - state = IDLE; all valid bits = 0; word counter = 0.
  - mem_req = 0; mem_addr = 0.
  - As a result hit = 0 and instr1/instr2 = 0.
  - Data and tag arrays are not reset.
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - If invalidate=1, clear all valid bits and stay in IDLE. This takes priority over miss detection.
  - Otherwise, if !hitA, latch line A's address and index. Else if !hitB, latch line B's address and index.
  - On either miss: clear valid of the target index, set mem_addr = {line addr, 4'b0} and mem_req = 1, and go to REQ.
  - Misses on both lines are serviced one line at a time: A first, then B after returning to IDLE.
- REQ:
  - Hold mem_req = 1 and mem_addr stable until mem_ack = 1 is sampled.
  - On ack: mem_req = 0 on the next cycle, counter = 0, go to FILL.
  - mem_rvalid is ignored in REQ.
- FILL:
  - Each cycle with mem_rvalid = 1: write mem_rdata to data[idx][counter], then counter++.
  - Cycles with mem_rvalid = 0 are stalls: no write, counter holds.
  - On the 4th valid word: write the tag, set valid[idx] = 1 (unless the kill flag is set), go to IDLE.
- pc changes during REQ/FILL do not abort the refill. The line in flight always completes, and the new pc is evaluated in IDLE.
- invalidate during REQ/FILL sets a kill flag:
  - The refill completes, but the line is not marked valid.
  - All other valid bits are cleared immediately.
  - The kill flag clears on entry to IDLE.
- Latency: miss seen in IDLE at cycle 0 → mem_req high at cycle 1.
  - With mem_ack at cycle 1 and rvalid at cycles 2–5, hit = 1 at cycle 6.
  - A line-crossing double miss costs two such sequences back to back.
- A conflicting index evicts the old line: tag overwritten, no writeback (the cache is read-only).

Test Plan:
- Cold miss: reset, pc=0x00000000, mem_ack immediate, rdata 0x11,0x22,0x33,0x44 → mem_req at cycle 1 with mem_addr=0x0; hit=1 at cycle 6; instr1=0x11, instr2=0x22.
- Same-line hit: after the cold miss, pc=0x8 → hit=1 in the same cycle, instr1=0x33, instr2=0x44, mem_req stays 0.
- Line crossing: pc=0xC with only line 0 valid → one refill at mem_addr=0x10 with rdata 0x55..0x88 → hit=1, instr1=0x44, instr2=0x55.
- Conflict eviction (NUM_LINES=64): pc=0x400 after line 0 is filled → refill at 0x400; afterwards pc=0x0 misses again.
- Handshake stalls: mem_ack delayed 3 cycles, rvalid gapped 1-0-1-0-1-1 → mem_addr held stable; 4 words written in order; hit only after the final word.
- Reset/invalidate mid-fill: rst low after 2 words → mem_req=0, hit=0; a later fetch of the same pc refills from scratch. invalidate after 2 words → fill completes but hit stays 0 and the FSM re-requests the line.
